// File: rtl/time_syn_rx_mc.sv
// Receive-side parser for two-beat time-sync frames on an always-ready AXI-Stream.
// Decodes three message types, tracks per-type sequence continuity and counts dropped frames.
module time_syn_rx_mc #(
  parameter int          P_DATA_WIDTH = 64,
  parameter logic [7:0]  P_TS_TYPE    = 8'h66,
  parameter logic [7:0]  P_STD_TYPE   = 8'h88,
  parameter logic [7:0]  P_RET_TYPE   = 8'h55,
  parameter int          P_ERR_CNT_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx_axis_tvalid,
  input  logic [P_DATA_WIDTH-1:0]   i_rx_axis_tdata,
  input  logic                      i_rx_axis_tlast,
  input  logic [P_DATA_WIDTH/8-1:0] i_rx_axis_tkeep,
  input  logic                      i_rx_axis_tuser,
  input  logic                      i_err_clr,
  output logic [P_DATA_WIDTH-1:0]   o_recv_data,
  output logic [7:0]                o_recv_seq,
  output logic                      o_recv_ts_valid,
  output logic                      o_recv_std_valid,
  output logic                      o_recv_return_valid,
  output logic                      o_seq_gap,
  output logic                      o_frame_err,
  output logic [1:0]                o_err_code,
  output logic [P_ERR_CNT_W-1:0]    o_err_cnt,
  output logic [1:0]                o_dbg_state
);

  // Handshake: no tready, every beat with tvalid=1 is consumed on the clock edge it is presented.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [P_ERR_CNT_W-1:0] CNT_ONE = P_ERR_CNT_W'(1);

  state_t                    state_q, state_d;
  logic [1:0]                type_idx_q, type_idx_d;
  logic [7:0]                seq_q;
  logic [P_DATA_WIDTH-1:0]   recv_data_q;
  logic [7:0]                recv_seq_q;
  logic                      ts_vld_q, std_vld_q, ret_vld_q, seq_gap_q, frame_err_q;
  logic [1:0]                err_code_q, err_code_d;
  logic [P_ERR_CNT_W-1:0]    err_cnt_q;
  logic [7:0]                last_seq_q [0:3];
  logic [3:0]                seen_q;

  logic       beat_bad, type_known, load_hdr_d, acc_d, err_det_d, gap_d;
  logic [7:0] hdr_type, next_seq;

  always_comb begin
    hdr_type   = i_rx_axis_tdata[7:0];
    beat_bad   = i_rx_axis_tuser || (i_rx_axis_tkeep != '1);
    type_known = 1'b1;
    type_idx_d = 2'd0;
    if (hdr_type == P_TS_TYPE)       type_idx_d = 2'd0;
    else if (hdr_type == P_STD_TYPE) type_idx_d = 2'd1;
    else if (hdr_type == P_RET_TYPE) type_idx_d = 2'd2;
    else                             type_known = 1'b0;

    state_d    = state_q;
    err_code_d = err_code_q;
    err_det_d  = 1'b0;
    acc_d      = 1'b0;
    load_hdr_d = 1'b0;
    if (i_rx_axis_tvalid) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_axis_tlast) begin
            err_det_d = 1'b1; err_code_d = 2'd1;
          end else if (beat_bad) begin
            err_det_d = 1'b1; err_code_d = 2'd3; state_d = S_DISCARD;
          end else if (!type_known) begin
            err_det_d = 1'b1; err_code_d = 2'd0; state_d = S_DISCARD;
          end else begin
            load_hdr_d = 1'b1; state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!i_rx_axis_tlast) begin
            err_det_d = 1'b1; err_code_d = 2'd2; state_d = S_DISCARD;
          end else if (beat_bad) begin
            err_det_d = 1'b1; err_code_d = 2'd3; state_d = S_IDLE;
          end else begin
            acc_d = 1'b1; state_d = S_IDLE;
          end
        end
        S_DISCARD: if (i_rx_axis_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // 8-bit add wraps, so FF followed by 00 counts as continuous.
    next_seq = last_seq_q[type_idx_q] + 8'd1;
    gap_d    = seen_q[type_idx_q] && (seq_q != next_seq);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      type_idx_q  <= 2'd0;
      seq_q       <= 8'd0;
      recv_data_q <= '0;
      recv_seq_q  <= 8'd0;
      ts_vld_q    <= 1'b0;
      std_vld_q   <= 1'b0;
      ret_vld_q   <= 1'b0;
      seq_gap_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= '0;
      seen_q      <= 4'd0;
      for (int i = 0; i < 4; i++) last_seq_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      ts_vld_q    <= acc_d && (type_idx_q == 2'd0);
      std_vld_q   <= acc_d && (type_idx_q == 2'd1);
      ret_vld_q   <= acc_d && (type_idx_q == 2'd2);
      seq_gap_q   <= acc_d && gap_d;
      frame_err_q <= err_det_d;
      if (err_det_d) err_code_q <= err_code_d;
      if (load_hdr_d) begin
        type_idx_q <= type_idx_d;
        seq_q      <= i_rx_axis_tdata[15:8];
      end
      if (acc_d) begin
        recv_data_q            <= i_rx_axis_tdata;
        recv_seq_q             <= seq_q;
        last_seq_q[type_idx_q] <= seq_q;
        seen_q[type_idx_q]     <= 1'b1;
      end
      // Clear dominates a same-cycle error; the pulse above still fires.
      if (i_err_clr) err_cnt_q <= '0;
      else if (err_det_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign o_recv_data         = recv_data_q;
  assign o_recv_seq          = recv_seq_q;
  assign o_recv_ts_valid     = ts_vld_q;
  assign o_recv_std_valid    = std_vld_q;
  assign o_recv_return_valid = ret_vld_q;
  assign o_seq_gap           = seq_gap_q;
  assign o_frame_err         = frame_err_q;
  assign o_err_code          = err_code_q;
  assign o_err_cnt           = err_cnt_q;
  assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_time_syn_rx_mc.sv
// Bench for time_syn_rx_mc: frame-level reference model feeds an expected queue,
// a negedge monitor pops and compares every valid/error event the DUT emits.
module tb_time_syn_rx_mc;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 2;
  localparam int EW = 2 + 1 + 2 + CW + 8 + DW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk, rst_n;
  logic          tvalid, tlast, tuser, err_clr;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [DW-1:0] recv_data;
  logic [7:0]    recv_seq;
  logic          ts_vld, std_vld, ret_vld, seq_gap, frame_err;
  logic [1:0]    err_code, dbg_state;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state, frame level
  logic [7:0]    m_last [3];
  bit            m_seen [3];
  logic [DW-1:0] m_data;
  logic [7:0]    m_seq;
  logic [1:0]    m_code;
  logic [CW-1:0] m_cnt;
  bit            gaps_en;

  time_syn_rx_mc #(.P_DATA_WIDTH(DW), .P_ERR_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser), .i_err_clr(err_clr),
    .o_recv_data(recv_data), .o_recv_seq(recv_seq),
    .o_recv_ts_valid(ts_vld), .o_recv_std_valid(std_vld), .o_recv_return_valid(ret_vld),
    .o_seq_gap(seq_gap), .o_frame_err(frame_err), .o_err_code(err_code),
    .o_err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input logic [1:0] k, input logic g, input logic [1:0] c,
                                         input logic [CW-1:0] n, input logic [7:0] s,
                                         input logic [DW-1:0] d);
    return {k, g, c, n, s, d};
  endfunction

  function automatic int type_index(input logic [7:0] t);
    if (t == 8'h66) return 0;
    if (t == 8'h88) return 1;
    if (t == 8'h55) return 2;
    return -1;
  endfunction

  task automatic check_vec(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_last[i] = 8'd0; m_seen[i] = 1'b0; end
    m_data = '0; m_seq = 8'd0; m_code = 2'd0; m_cnt = '0;
  endtask

  // driver
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [KW-1:0] keep,
                           input logic user, input logic clr);
    tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep; tuser = user; err_clr = clr;
    @(posedge clk); #1;
    tvalid = 1'b0; err_clr = 1'b0; tuser = 1'b0; tlast = 1'b0;
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      tdata = {$urandom, $urandom}; tlast = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      tlast = 1'b0;
    end
  endtask

  // bad: 0 clean, 1 tuser set, 2 keep not all ones
  task automatic send_frame(input logic [7:0] typ, input logic [7:0] seq, input logic [DW-1:0] pay,
                            input int len, input int hdr_bad, input int pay_bad, input bit clr);
    int idx, det, code;
    logic [DW-1:0] d;
    logic [7:0] nx;
    logic gap;
    idx = type_index(typ);
    det = -1; code = 0;
    if (len == 1)            begin code = 1; det = 0; end
    else if (hdr_bad != 0)   begin code = 3; det = 0; end
    else if (idx < 0)        begin code = 0; det = 0; end
    else if (len > 2)        begin code = 2; det = 1; end
    else if (pay_bad != 0)   begin code = 3; det = 1; end
    if (det < 0) begin
      nx = m_last[idx] + 8'd1;
      gap = m_seen[idx] && (seq != nx);
      m_data = pay; m_seq = seq; m_last[idx] = seq; m_seen[idx] = 1'b1;
      exp_q.push_back(pack(2'(idx), gap, m_code, m_cnt, m_seq, m_data));
    end else begin
      m_code = 2'(code);
      if (clr) m_cnt = '0;
      else if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      exp_q.push_back(pack(2'd3, 1'b0, m_code, m_cnt, m_seq, m_data));
    end
    for (int b = 0; b < len; b++) begin
      logic [KW-1:0] keep;
      logic user;
      int bad;
      d = {$urandom, $urandom};
      if (b == 0) d[15:0] = {seq, typ};
      else if (b == 1) d = pay;
      bad = (b == 0) ? hdr_bad : (b == 1) ? pay_bad : 0;
      user = (bad == 1);
      keep = (bad == 2) ? KW'($urandom_range(0, 254)) : '1;
      send_beat(d, b == len - 1, keep, user, clr && (b == det));
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      int n_ev;
      logic [1:0] kind;
      logic [EW-1:0] e;
      n_ev = int'(ts_vld) + int'(std_vld) + int'(ret_vld) + int'(frame_err);
      if (n_ev > 1) begin
        checks++; errors++;
        $display("FAIL event_onehot: got %0d simultaneous events expected 1", n_ev);
      end else if (n_ev == 1) begin
        kind = ts_vld ? 2'd0 : std_vld ? 2'd1 : ret_vld ? 2'd2 : 2'd3;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = exp_q.pop_front();
          check_vec("event", pack(kind, seq_gap, err_code, err_cnt, recv_seq, recv_data), e);
        end
      end else if (seq_gap) begin
        checks++; errors++;
        $display("FAIL lone_gap: got o_seq_gap=1 expected 0 without valid");
      end
    end
  end

  initial begin
    tvalid = 1'b0; tdata = '0; tlast = 1'b0; tkeep = '1; tuser = 1'b0; err_clr = 1'b0;
    gaps_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("reset_outputs", pack({ts_vld | std_vld, ret_vld | frame_err}, seq_gap, err_code,
              err_cnt, recv_seq, recv_data), '0);
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    send_frame(8'h66, 8'd5, 64'h0000_0012_3456_789A, 2, 0, 0, 0);
    send_frame(8'h55, 8'hFE, {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h55, 8'hFF, {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h88, 8'd9,  {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h55, 8'h00, {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h55, 8'h02, {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h66, 8'd6, {$urandom, $urandom}, 1, 0, 0, 0);
    send_frame(8'h88, 8'd10, {$urandom, $urandom}, 3, 0, 0, 0);
    send_frame(8'h88, 8'd10, {$urandom, $urandom}, 2, 0, 1, 0);
    send_frame(8'h88, 8'd10, {$urandom, $urandom}, 2, 0, 2, 0);
    send_frame(8'h11, 8'd1, {$urandom, $urandom}, 2, 0, 0, 0);
    send_frame(8'h88, 8'd10, {$urandom, $urandom}, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) send_frame(8'h66, 8'd0, '0, 1, 0, 0, 0);
    send_frame(8'h66, 8'd0, '0, 1, 0, 0, 1);
    send_frame(8'h88, 8'd10, {$urandom, $urandom}, 2, 0, 0, 0);

    // reset between header and payload
    send_beat({48'h0, 8'd20, 8'h66}, 1'b0, '1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_vec("midframe_reset_outputs", pack({ts_vld | std_vld, ret_vld | frame_err}, seq_gap,
              err_code, err_cnt, recv_seq, recv_data), '0);
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL midframe_reset_state: got %0d expected 0", dbg_state); end
    send_frame(8'h66, 8'd20, 64'hDEAD_BEEF, 1, 0, 0, 0);
    send_frame(8'h66, 8'd77, 64'h1234_5678, 2, 0, 0, 0);

    // randomized traffic with idle gaps
    gaps_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r, idx, len, hb, pb;
      logic [7:0] typ, seq;
      r = $urandom_range(0, 7);
      case (r)
        0, 1: typ = 8'h66;
        2, 3: typ = 8'h88;
        4, 5: typ = 8'h55;
        6:    typ = 8'h11;
        default: typ = 8'($urandom);
      endcase
      idx = type_index(typ);
      seq = 8'($urandom);
      if (idx >= 0 && $urandom_range(0, 3) != 0) seq = m_last[idx] + 8'd1;
      r = $urandom_range(0, 9);
      len = (r == 0) ? 1 : (r == 1) ? $urandom_range(3, 4) : 2;
      hb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      pb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      send_frame(typ, seq, {$urandom, $urandom}, len, hb, pb, $urandom_range(0, 7) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_syn_rx_mc.md
Name: time_syn_rx_mc

Overview:
- Parametrised receive-side parser for time-synchronisation frames on a receive-only AXI-Stream input (no tready; always accepting).
- Each frame is exactly two beats: a header beat carrying message type and sequence number, then a payload beat carrying the time value.
- Decodes three message types (timestamp, standard time, return timestamp) and emits the payload with a per-type one-cycle valid pulse.
- Adds framing checks, per-type sequence-gap detection and a saturating error counter; sits between the MAC RX AXIS and the time-sync controller.

Parameters:
P_DATA_WIDTH, 64, AXIS data and payload width; multiple of 8, minimum 16
P_TS_TYPE, 8'h66, type code for timestamp message
P_STD_TYPE, 8'h88, type code for standard-time message
P_RET_TYPE, 8'h55, type code for return-timestamp message
P_ERR_CNT_W, 16, width of the error counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_rx_axis_tvalid  in  1  beat valid
i_rx_axis_tdata  in  P_DATA_WIDTH  beat data
i_rx_axis_tlast  in  1  last beat of frame
i_rx_axis_tkeep  in  P_DATA_WIDTH/8  byte enables
i_rx_axis_tuser  in  1  MAC error flag for the beat
i_err_clr  in  1  synchronous clear of o_err_cnt
o_recv_data  out  P_DATA_WIDTH  payload of the last accepted frame
o_recv_seq  out  8  sequence number of the last accepted frame
o_recv_ts_valid  out  1  pulse: timestamp frame accepted
o_recv_std_valid  out  1  pulse: standard-time frame accepted
o_recv_return_valid  out  1  pulse: return frame accepted
o_seq_gap  out  1  pulse, coincident with a valid pulse: sequence discontinuity
o_frame_err  out  1  pulse: frame dropped
o_err_code  out  2  cause of the last drop: 1=runt, 2=oversize, 3=bad keep/tuser, 0=unknown type
o_err_cnt  out  P_ERR_CNT_W  saturating count of dropped frames

Behaviour:
- Reset is synchronous on i_rst_n low, and wins over all other inputs.
  - All outputs go to 0.
  - The FSM goes to IDLE.
  - The per-type last-sequence registers and their seen-flags are cleared.
- Only beats with tvalid=1 are processed; tvalid=0 cycles are ignored in every state.
- Header beat layout: tdata[7:0] = type, tdata[15:8] = seq; the remaining bits are ignored.
- FSM states: IDLE, PAYLOAD, DISCARD.
- IDLE, on a valid beat:
  - tlast=1: runt error; stay in IDLE.
  - else tuser=1 or tkeep not all ones: code 3; go to DISCARD.
  - else type not one of the three codes: code 0; go to DISCARD.
  - else latch type and seq; go to PAYLOAD.
- PAYLOAD, on a valid beat:
  - tlast=0: oversize error; go to DISCARD.
  - else tuser=1 or tkeep not all ones: code 3; go to IDLE.
  - else accept the frame and go to IDLE.
- DISCARD: on a valid beat with tlast=1, go to IDLE. Errors are counted once per frame, at detection only.
- Accept (cycle after the final beat, latency 1 clock):
  - o_recv_data is set to the payload beat and o_recv_seq to the latched seq.
  - Exactly one of the three valid pulses is high for one cycle.
  - o_recv_data and o_recv_seq hold until the next accept.
- Sequence check, per type:
  - If that type's seen-flag is set and seq != (last_seq+1) mod 256, o_seq_gap pulses with the valid pulse. 8'hFF followed by 8'h00 is not a gap.
  - The first frame of a type after reset never flags a gap.
  - last_seq is updated and seen is set on every accept.
- Error output:
  - o_frame_err pulses for one cycle, the cycle after the detecting beat.
  - o_err_code updates on the same edge and holds its value.
  - o_err_cnt increments on the same edge and saturates at all ones.
- i_err_clr:
  - When i_err_clr=1, o_err_cnt goes to 0 on the next edge, even if an error is detected in the same cycle; that error is not counted.
  - The o_frame_err pulse is still issued.
- Accept and error events are mutually exclusive within a cycle.
- Back-to-back frames with no idle gap are fully supported.
- Reset mid-frame: the next valid beat is treated as a header. A trailing payload beat with tlast=1 is therefore a runt error.

Test Plan:
- Header type=8'h66, seq=5, then payload 64'h0000_0012_3456_789A with tlast, keep=8'hFF -> one cycle after the payload beat: o_recv_ts_valid=1 for 1 cycle, o_recv_data=64'h0000_0012_3456_789A, o_recv_seq=5, o_seq_gap=0.
- Return frames with seq 8'hFE, 8'hFF, 8'h00, then 8'h02 -> three o_recv_return_valid pulses without o_seq_gap; the fourth pulse has o_seq_gap=1. An interleaved std frame with seq=9 gives no gap.
- Single-beat frame (tlast on header) -> o_frame_err=1, o_err_code=1, o_err_cnt=1, no valid pulse. A three-beat std frame -> o_err_code=2, o_err_cnt=2, and beat 3 is silently discarded.
- Payload beat with tuser=1, and separately keep=8'h7F -> each drops with o_err_code=3. Header type=8'h11 over a 2-beat frame -> o_err_code=0. All drops: no valid pulses.
- Set P_ERR_CNT_W=2 and send 5 bad frames -> o_err_cnt sticks at 3. Then i_err_clr coincident with a 6th error -> o_err_cnt=0 and o_frame_err pulses.
- Drive i_rst_n low for one cycle between header and payload -> outputs 0 and FSM in IDLE. The payload beat with tlast then gives a runt error, and a following good frame is accepted with no gap.
